// File: rtl/vga_pkg.sv
// Shared VGA/frame-buffer constants, the RGB444 pixel type and the per-channel
// averaging helper used by the bilinear read path.
`timescale 1ns/1ps
package vga_pkg;

    localparam int SRC_W = 320;
    localparam int SRC_H = 240;
    localparam int DST_W = 640;
    localparam int DST_H = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Channels are averaged independently; a carry must never cross into a neighbour.
    function automatic rgb444_t avg4(input rgb444_t a, input rgb444_t b);
        logic [4:0] sr, sg, sb;
        rgb444_t    o;
        sr  = {1'b0, a.r} + {1'b0, b.r};
        sg  = {1'b0, a.g} + {1'b0, b.g};
        sb  = {1'b0, a.b} + {1'b0, b.b};
        o.r = sr[4:1];
        o.g = sg[4:1];
        o.b = sb[4:1];
        return o;
    endfunction

endpackage

// File: rtl/bilinear_line_buffer.sv
// One source row of RGB444 pixels: simple dual-port RAM, one write port and a
// registered read port, so it maps onto a block RAM.
`timescale 1ns/1ps
module bilinear_line_buffer
    import vga_pkg::*;
#(
    parameter int DEPTH = SRC_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          pclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rgb444_t       wdata,
    input  logic [AW-1:0] raddr,
    output rgb444_t       rdata
);

    rgb444_t mem [DEPTH];

    // Contents are never cleared; the even row always refills before it is read.
    always_ff @(posedge pclk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bilinear_frame_reader.sv
// Frame-buffer read side: fetches 320x240 RGB444 pixels in step with VGA timing
// and outputs a 2x bilinear upscale at 640x480, three pixel clocks behind the input.
`timescale 1ns/1ps
module bilinear_frame_reader #(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic [9:0]        x_pixel,
    input  logic [9:0]        y_pixel,
    input  logic              display_en,
    output logic [ADDR_W-1:0] rAddr,
    input  logic [11:0]       rData,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              de_out
);
    import vga_pkg::*;

    localparam int CW = $clog2(SRC_W);
    localparam int RW = $clog2(SRC_H);

    logic [CW-1:0] sx, rc;
    logic [RW-1:0] sy, rr;

    // Odd output coordinates fetch the next source neighbour, clamped at the far edge.
    always_comb begin
        sx = CW'(x_pixel >> 1);
        sy = RW'(y_pixel >> 1);
        rc = sx;
        rr = sy;
        if (x_pixel[0] && (sx != CW'(SRC_W - 1)))
            rc = sx + 1'b1;
        if (y_pixel[0] && (sy != RW'(SRC_H - 1)))
            rr = sy + 1'b1;
        rAddr = '0;
        if (display_en)
            rAddr = ADDR_W'(rr) * ADDR_W'(SRC_W) + ADDR_W'(rc);
    end

    // ---- stage 1: frame-buffer and line-buffer data arrive ----
    logic [CW-1:0] rc_p1;
    logic          xodd_p1, yodd_p1, vld_p1;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            rc_p1   <= '0;
            xodd_p1 <= 1'b0;
            yodd_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            rc_p1   <= rc;
            xodd_p1 <= x_pixel[0];
            yodd_p1 <= y_pixel[0];
            vld_p1  <= display_en;
        end
    end

    rgb444_t fb_pix, lb_pix;
    assign fb_pix = rgb444_t'(rData);

    // Even rows refill the buffer with the row the following odd row pairs against.
    bilinear_line_buffer #(
        .DEPTH (SRC_W)
    ) u_line_buffer (
        .pclk  (pclk),
        .we    (vld_p1 && !yodd_p1),
        .waddr (rc_p1),
        .wdata (fb_pix),
        .raddr (rc),
        .rdata (lb_pix)
    );

    // ---- stage 2: vertical interpolation ----
    rgb444_t v_p2;
    logic    xodd_p2, vld_p2;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            v_p2    <= '0;
            xodd_p2 <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            v_p2    <= yodd_p1 ? avg4(lb_pix, fb_pix) : fb_pix;
            xodd_p2 <= xodd_p1;
            vld_p2  <= vld_p1;
        end
    end

    // ---- stage 3: horizontal interpolation and output registers ----
    rgb444_t a_p3, out_p3;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            a_p3   <= '0;
            out_p3 <= '0;
            de_out <= 1'b0;
        end else begin
            de_out <= vld_p2;
            if (!vld_p2) begin
                out_p3 <= '0;
            end else if (!xodd_p2) begin
                out_p3 <= v_p2;
                a_p3   <= v_p2;
            end else begin
                out_p3 <= avg4(a_p3, v_p2);
            end
        end
    end

    assign red   = out_p3.r;
    assign green = out_p3.g;
    assign blue  = out_p3.b;

endmodule

// File: tb/tb_bilinear_frame_reader.sv
// Bench for bilinear_frame_reader: frame-buffer model plus a bilinear reference
// computed straight from source pixels, compared three clocks behind the stimulus.
`timescale 1ns/1ps
module tb_bilinear_frame_reader;

    localparam int SRC_W  = 320;
    localparam int SRC_H  = 240;
    localparam int ADDR_W = 17;

    logic              pclk = 1'b0;
    logic              reset;
    logic [9:0]        x_pixel, y_pixel;
    logic              display_en;
    logic [ADDR_W-1:0] rAddr;
    logic [11:0]       rData;
    logic [3:0]        red, green, blue;
    logic              de_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int x;
        int y;
        bit de;
        bit chk;
    } req_t;

    req_t       pend_q[$];
    logic [11:0] fb [0:SRC_W*SRC_H-1];

    bilinear_frame_reader #(
        .SRC_W  (SRC_W),
        .SRC_H  (SRC_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .x_pixel    (x_pixel),
        .y_pixel    (y_pixel),
        .display_en (display_en),
        .rAddr      (rAddr),
        .rData      (rData),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .de_out     (de_out)
    );

    always #20 pclk = ~pclk;

    // Frame buffer: data valid one clock after the address.
    always @(posedge pclk) rData <= fb[rAddr];

    // ---------------- reference model ----------------
    function automatic int clampi(int v, int hi);
        return (v > hi) ? hi : v;
    endfunction

    function automatic logic [11:0] avg12(logic [11:0] a, logic [11:0] b);
        int r, g, bl;
        r  = (int'(a[11:8]) + int'(b[11:8])) / 2;
        g  = (int'(a[7:4])  + int'(b[7:4]))  / 2;
        bl = (int'(a[3:0])  + int'(b[3:0]))  / 2;
        return {4'(r), 4'(g), 4'(bl)};
    endfunction

    function automatic logic [11:0] vert(int c, int y);
        int sy;
        sy = y / 2;
        if (y % 2 == 0)
            return fb[sy*SRC_W + c];
        return avg12(fb[sy*SRC_W + c], fb[clampi(sy + 1, SRC_H - 1)*SRC_W + c]);
    endfunction

    function automatic logic [12:0] ref_out(req_t p);
        int sx;
        if (!p.de)
            return 13'h0;
        sx = p.x / 2;
        if (p.x % 2 == 0)
            return {1'b1, vert(sx, p.y)};
        return {1'b1, avg12(vert(sx, p.y), vert(clampi(sx + 1, SRC_W - 1), p.y))};
    endfunction

    function automatic logic [ADDR_W-1:0] ref_addr(int x, int y, bit de);
        int rc, rr;
        if (!de)
            return '0;
        rc = (x % 2 == 0) ? x / 2 : clampi(x / 2 + 1, SRC_W - 1);
        rr = (y % 2 == 0) ? y / 2 : clampi(y / 2 + 1, SRC_H - 1);
        return ADDR_W'(rr * SRC_W + rc);
    endfunction

    // One pixel clock: hands back the output due for the pixel driven three clocks ago.
    task automatic drive_pix(input int x, input int y, input bit de, input bit chk,
                             output bit popped, output req_t p,
                             output logic [12:0] got, output logic [ADDR_W-1:0] addr);
        req_t r;
        popped = 1'b0;
        p      = '{0, 0, 1'b0, 1'b0};
        got    = '0;
        @(negedge pclk);
        if (pend_q.size() == 3) begin
            p      = pend_q.pop_front();
            popped = p.chk;
            got    = {de_out, red, green, blue};
        end
        x_pixel    = 10'(x);
        y_pixel    = 10'(y);
        display_en = de;
        #1;
        addr = rAddr;
        r    = '{x, y, de, chk};
        pend_q.push_back(r);
    endtask

    // Stimulus index i over one line: 640 active pixels, then 4 blanking clocks.
    function automatic int line_x(int i);
        return (i < 640) ? i : 640 + int'($urandom_range(0, 150));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset      = 1'b0;
        display_en = 1'b0;
        x_pixel    = '0;
        y_pixel    = '0;
        repeat (3) @(negedge pclk);
        #1;
        n_checks++;
        if ({de_out, red, green, blue} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h expected 0000", {de_out, red, green, blue});
        end
        n_checks++;
        if (rAddr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr got %0d expected 0", rAddr);
        end
        @(negedge pclk);
        reset = 1'b1;
    endtask

    task automatic test_point();
        bit popped; req_t p; logic [12:0] got; logic [ADDR_W-1:0] addr;
        for (int c = 0; c < SRC_W; c++)
            for (int r = 0; r < SRC_H; r++)
                fb[r*SRC_W + c] = {4'(c), 4'(r), 4'h5};
        for (int i = 0; i < 14; i++) begin
            drive_pix((i < 10) ? i : 700, 6, i < 10, 1'b1, popped, p, got, addr);
            if (popped) begin
                n_checks++;
                if (got !== ref_out(p) || (p.de && (p.x == 4 || p.x == 5) && got !== 13'h1235)) begin
                    n_fail++;
                    $display("FAIL point_out x=%0d y=%0d got %h expected %h", p.x, p.y, got, ref_out(p));
                end
            end
            n_checks++;
            if (addr !== ref_addr((i < 10) ? i : 700, 6, i < 10)
                || (i == 4 && addr !== 17'd962) || (i == 5 && addr !== 17'd963)) begin
                n_fail++;
                $display("FAIL point_addr i=%0d got %0d expected %0d", i, addr,
                         ref_addr((i < 10) ? i : 700, 6, i < 10));
            end
        end
    endtask

    task automatic test_row_average();
        bit popped; req_t p; logic [12:0] got, want; logic [ADDR_W-1:0] addr;
        int x;
        for (int c = 0; c < SRC_W; c++) begin
            fb[3*SRC_W + c] = 12'h000;
            fb[4*SRC_W + c] = 12'hFFF;
        end
        for (int y = 6; y <= 7; y++) begin
            for (int i = 0; i < 644; i++) begin
                x = line_x(i);
                drive_pix(x, y, i < 640, 1'b1, popped, p, got, addr);
                if (popped) begin
                    n_checks++;
                    want = !p.de ? 13'h0 : (p.y == 7) ? 13'h1777 : 13'h1000;
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL row_average x=%0d y=%0d got %h expected %h", p.x, p.y, got, want);
                    end
                end
                n_checks++;
                if (addr !== ref_addr(x, y, i < 640)) begin
                    n_fail++;
                    $display("FAIL row_average_addr x=%0d y=%0d got %0d expected %0d", x, y, addr,
                             ref_addr(x, y, i < 640));
                end
            end
        end
    endtask

    task automatic test_random_rows();
        bit popped; req_t p; logic [12:0] got; logic [ADDR_W-1:0] addr;
        int x, y, k;
        for (int i = 0; i < SRC_W*SRC_H; i++)
            fb[i] = 12'($urandom);
        for (int pr = 0; pr < 3; pr++) begin
            k = (pr == 0) ? 0 : int'($urandom_range(1, SRC_H - 2));
            for (int h = 0; h < 2; h++) begin
                y = 2*k + h;
                for (int i = 0; i < 644; i++) begin
                    x = line_x(i);
                    drive_pix(x, y, i < 640, 1'b1, popped, p, got, addr);
                    if (popped) begin
                        n_checks++;
                        if (got !== ref_out(p)) begin
                            n_fail++;
                            $display("FAIL random_rows x=%0d y=%0d got %h expected %h", p.x, p.y, got, ref_out(p));
                        end
                    end
                    n_checks++;
                    if (addr !== ref_addr(x, y, i < 640)) begin
                        n_fail++;
                        $display("FAIL random_rows_addr x=%0d y=%0d got %0d expected %0d", x, y, addr,
                                 ref_addr(x, y, i < 640));
                    end
                end
            end
        end
    endtask

    task automatic test_corner();
        bit popped; req_t p; logic [12:0] got; logic [ADDR_W-1:0] addr;
        int x;
        fb[239*SRC_W + 319] = 12'hA5C;
        for (int y = 478; y <= 479; y++) begin
            for (int i = 0; i < 644; i++) begin
                x = line_x(i);
                drive_pix(x, y, i < 640, 1'b1, popped, p, got, addr);
                if (popped) begin
                    n_checks++;
                    if (got !== ref_out(p) || (p.de && p.x == 639 && p.y == 479 && got !== 13'h1A5C)) begin
                        n_fail++;
                        $display("FAIL corner x=%0d y=%0d got %h expected %h", p.x, p.y, got, ref_out(p));
                    end
                end
                n_checks++;
                if (addr !== ref_addr(x, y, i < 640) || (x == 639 && y == 479 && addr !== 17'd76799)) begin
                    n_fail++;
                    $display("FAIL corner_addr x=%0d y=%0d got %0d expected %0d", x, y, addr,
                             ref_addr(x, y, i < 640));
                end
            end
        end
    endtask

    task automatic test_blanking();
        bit popped; req_t p; logic [12:0] got; logic [ADDR_W-1:0] addr;
        int x, y;
        bit de;
        // Even row, long blanking with in-range coordinates, then the odd row.
        for (int i = 0; i < 640 + 60 + 640; i++) begin
            de = (i < 640) || (i >= 700);
            x  = (i < 640) ? i : (i < 700) ? int'($urandom_range(0, 639)) : i - 700;
            y  = (i < 640) ? 100 : (i < 700) ? int'($urandom_range(0, 479)) : 101;
            drive_pix(x, y, de, 1'b1, popped, p, got, addr);
            if (popped) begin
                n_checks++;
                if (got !== ref_out(p)) begin
                    n_fail++;
                    $display("FAIL blanking x=%0d y=%0d de=%0d got %h expected %h", p.x, p.y, p.de, got, ref_out(p));
                end
            end
            n_checks++;
            if (addr !== ref_addr(x, y, de)) begin
                n_fail++;
                $display("FAIL blanking_addr x=%0d y=%0d de=%0d got %0d expected %0d", x, y, de, addr,
                         ref_addr(x, y, de));
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive_pix(700, 101, 1'b0, 1'b1, popped, p, got, addr);
            if (popped) begin
                n_checks++;
                if (got !== ref_out(p)) begin
                    n_fail++;
                    $display("FAIL blanking_tail x=%0d y=%0d got %h expected %h", p.x, p.y, got, ref_out(p));
                end
            end
        end
    endtask

    task automatic test_reset_midrow();
        bit popped; req_t p; logic [12:0] got; logic [ADDR_W-1:0] addr;
        int x;
        for (int i = 0; i < 300; i++)
            drive_pix(i, 20, 1'b1, 1'b0, popped, p, got, addr);
        #5;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({de_out, red, green, blue} !== 13'h0) begin
            n_fail++;
            $display("FAIL async_reset got %h expected 0000", {de_out, red, green, blue});
        end
        repeat (2) @(negedge pclk);
        display_en = 1'b0;
        pend_q.delete();
        reset = 1'b1;
        for (int y = 22; y <= 23; y++) begin
            for (int i = 0; i < 644; i++) begin
                x = line_x(i);
                drive_pix(x, y, i < 640, 1'b1, popped, p, got, addr);
                if (popped) begin
                    n_checks++;
                    if (got !== ref_out(p)) begin
                        n_fail++;
                        $display("FAIL after_reset x=%0d y=%0d got %h expected %h", p.x, p.y, got, ref_out(p));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_point();
        test_row_average();
        test_random_rows();
        test_corner();
        test_blanking();
        test_reset_midrow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bilinear_frame_reader.md
Name: bilinear_frame_reader

Overview:
- Read side of the camera frame buffer. The capture writer stores 320x240 RGB444 pixels at address row*320+col.
- This block reads the buffer in step with the VGA timing counters and produces 640x480 RGB444 output, upscaled 2x with bilinear interpolation.
- A one-line buffer holds the upper source row, so only one frame-buffer read port is needed (one read per pixel clock).
- Sits between the frame buffer read port and the VGA RGB output pins.

Parameters:
- SRC_W, 320, source columns per row.
- SRC_H, 240, source rows per frame.
- ADDR_W, 17, frame-buffer address width.

Ports:
- pclk  in  1  pixel clock (25 MHz VGA clock). Single clock domain.
- reset  in  1  asynchronous, active-low reset.
- x_pixel  in  10  VGA column, 0..639 when display_en=1.
- y_pixel  in  10  VGA row, 0..479 when display_en=1.
- display_en  in  1  active-video qualifier from the VGA timing block.
- rAddr  out  ADDR_W  frame-buffer read address, combinational.
- rData  in  12  frame-buffer data. Format {R[11:8],G[7:4],B[3:0]}. Valid 1 cycle after rAddr.
- red  out  4  output red, registered.
- green  out  4  output green, registered.
- blue  out  4  output blue, registered.
- de_out  out  1  display_en delayed to align with red/green/blue.

Behaviour:
- Source coordinates: sx = x_pixel>>1, sy = y_pixel>>1.
- Requested column rc:
  - x_pixel even: rc = sx.
  - x_pixel odd: rc = min(sx+1, SRC_W-1).
- Requested row rr:
  - y_pixel even: rr = sy.
  - y_pixel odd: rr = min(sy+1, SRC_H-1).
- rAddr = rr*SRC_W + rc when display_en=1, else 0. Computed combinationally (cycle 0).
- Line buffer: SRC_W x 12, synchronous read with 1-cycle latency.
  - Read address = rc, every cycle.
  - Write: address rc, data rData, at cycle 1, only when the cycle-0 pixel had display_en=1 and y even.
  - Duplicate writes of the same column are harmless.
- Stage 1 (cycle 1): rData and the line-buffer output arrive. yodd, xodd and de are delayed one stage.
- Stage 2 (register V, cycle 2):
  - Row odd: V = per-channel (lb + rData)>>1, using 5-bit sum and truncation.
  - Row even: V = rData.
- Stage 3 (output registers, cycle 3):
  - x even: out = V; V is also captured into register A.
  - x odd: out = per-channel (A + V)>>1, truncated.
- Latency: red/green/blue/de_out reflect the input (x,y,display_en) exactly 3 pclk cycles earlier.
- Blanking: when the delayed de = 0, red/green/blue = 0 and de_out = 0.
- Edges:
  - x = 639: rc clamps to 319, so the average is P(319) with itself.
  - y = 479: rr clamps to 239, so the average is row 239 with itself.
  - y = 0, even: uses row 0 directly; no line-buffer dependency.
- Line-buffer rule: odd row 2k+1 reads line-buffer row k, written during row 2k. Row 2k+2 then overwrites it with row k+1.
- The first odd row after reset or after a frame start is valid only if the preceding even row was displayed. The VGA timing block guarantees this.
- Reset (asserted low, async):
  - red/green/blue = 0, de_out = 0.
  - Pipeline registers and A cleared.
  - Line-buffer contents are undefined; no clear is required.
- Reset deassertion mid-frame: output is garbage until the next even row completes. Acceptable; no recovery logic.
- Arithmetic: every average is per 4-bit channel, never across the packed 12-bit word.

Decomposition:
- Package vga_pkg:
  - SRC_W, SRC_H, DST_W=640, DST_H=480.
  - typedef rgb444_t as packed struct {r,g,b} of 4 bits each.
  - Function avg4(a,b) = (a+b)>>1 per channel.
- Sub-module bilinear_line_buffer: SRC_W x 12 simple dual-port RAM, one write port and one synchronous read port, inferred as BRAM.

Test Plan:
- Frame-buffer model with P(c,r) = {c[3:0], r[3:0], 4'h5}. Drive (x=4, y=6, de=1) -> rAddr = 3*320+2 = 962. Three cycles later, out = {2,3,5}.
- x=5, y=6 -> rAddr = 963. Output is the average of P(2,3) and P(3,3): R = (2+3)>>1 = 2, G = 3, B = 5, de_out = 1.
- Full row y=6, then y=7 with P(c,3)=12'h000 and P(c,4)=12'hFFF -> row 7 outputs 12'h777 at every x. Row 6 outputs 12'h000.
- Corner x=639, y=479, P(319,239)=12'hA5C -> rAddr = 239*320+319 = 76799. Output = 12'hA5C (clamped self-average).
- display_en=0 over the blanking interval -> rAddr = 0. From 3 cycles after de falls until 3 cycles after it rises, de_out = 0 and RGB = 0.
- Assert reset (low) mid-row -> red/green/blue/de_out go to 0 immediately (asynchronous). After release and one full even row, odd-row output matches the reference model.
